// File: rtl/restore_pkg.sv
// Shared types and constants for the CPU state-restore sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, cpu_ctrl bit positions, per-phase control words,
// and a helper that maps a state to the control word it drives.
// The ERR state only exists when RESTORE_TIMEOUT_EN is defined.
package restore_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RESET,
        ENTER,
        LOAD,
        FLUSH,
        UPDATE,
        SETTLE,
        RUN
`ifdef RESTORE_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    // cpu_ctrl bit positions
    localparam int CTRL_RST_BIT     = 0;
    localparam int RESTORE_MODE_BIT = 1;
    localparam int REG_WRITE_BIT    = 2;
    localparam int REG_UPDATE_BIT   = 6;

    // Control words for each phase of the restore
    localparam logic [31:0] CTRL_HOLD    = 32'h0000_0001; // CPU_RST
    localparam logic [31:0] CTRL_RESTORE = 32'h0000_0003; // CPU_RST | RESTORE_MODE
    localparam logic [31:0] CTRL_LOAD    = 32'h0000_0007; // + REG_WRITE
    localparam logic [31:0] CTRL_UPDATE  = 32'h0000_0043; // CPU_RST | RESTORE_MODE | REG_UPDATE
    localparam logic [31:0] CTRL_RUN    = 32'h0000_0000;

    // Control word to present while in state s; IDLE keeps whatever was last driven.
    function automatic logic [31:0] ctrl_word(input state_t s, input logic [31:0] cur);
        logic [31:0] w;
        w = cur;
        case (s)
            RESET:       w = CTRL_HOLD;
            ENTER:       w = CTRL_RESTORE;
            LOAD, FLUSH: w = CTRL_LOAD;
            UPDATE:      w = CTRL_UPDATE;
            SETTLE:      w = CTRL_RESTORE;
            RUN:         w = CTRL_RUN;
`ifdef RESTORE_TIMEOUT_EN
            ERR:         w = CTRL_HOLD;
`endif
            default:     w = cur;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/restore_load_stage.sv
// LOAD-phase pop/capture stage: pops {addr,data} pairs from a FWFT FIFO into registered CPU writes.
// Latency: one cycle from an accepted pop to the matching cpu_write_enable pulse.
// Backpressure: pops only while load_active and words remain; stalls indefinitely on !dma_r_enable.
// Ports: load_init/n_words latch the word count; dma_re/dma_out/dma_r_enable form the FIFO read
// side; cpu_write_* is the registered CPU write port; last_xfer/remaining_zero feed the FSM.
module restore_load_stage
    import restore_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             load_active,
    input  logic             abort,
    input  logic             load_init,
    input  logic [CNT_W-1:0] n_words,
    input  logic [63:0]      dma_out,
    input  logic             dma_r_enable,
    output logic             dma_re,
    output logic             last_xfer,
    output logic             remaining_zero,
    output logic [31:0]      cpu_write_addr,
    output logic [31:0]      cpu_write_data,
    output logic             cpu_write_enable
);

    logic [CNT_W-1:0] remaining;
    logic             xfer;

    assign remaining_zero = (remaining == '0);

    // Combinational pop: dropping as soon as the count hits zero avoids an over-read.
    // Abort also masks it so the head word stays in the FIFO for the next attempt.
    assign dma_re    = load_active && !abort && !remaining_zero;
    assign xfer      = dma_re && dma_r_enable;
    assign last_xfer = xfer && (remaining == CNT_W'(1));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            remaining        <= '0;
            cpu_write_addr   <= '0;
            cpu_write_data   <= '0;
            cpu_write_enable <= 1'b0;
        end else begin
            // xfer implies remaining != 0, so the count never wraps
            if (load_init) begin
                remaining <= n_words;
            end else if (xfer) begin
                remaining <= remaining - CNT_W'(1);
            end

            cpu_write_enable <= xfer;
            if (xfer) begin
                cpu_write_addr <= dma_out[63:32];
                cpu_write_data <= dma_out[31:0];
            end
        end
    end

endmodule

// File: rtl/restore_seq.sv
// CPU state-restore sequencer: reset CPU, enter restore mode, load N pairs, update regs, run.
// Latency: RST_CYCLES + ENTER_CYCLES + N + 1 + UPD_CYCLES + 2 cycles from start to done (no stalls).
// Backpressure: LOAD waits on dma_r_enable; with RESTORE_TIMEOUT_EN a stall of TIMEOUT_CYCLES goes to ERR.
// Ports: start/abort/n_words control; dma_* is the FIFO read side; cpu_write_*/cpu_ctrl drive
// the CPU; busy/done/error report status. Optional macro: RESTORE_TIMEOUT_EN (stall timeout + ERR).
module restore_seq
    import restore_pkg::*;
#(
    parameter int RST_CYCLES     = 10,
    parameter int ENTER_CYCLES   = 10,
    parameter int UPD_CYCLES     = 2000,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] n_words,
    input  logic [63:0]      dma_out,
    input  logic             dma_r_enable,
    output logic             dma_re,
    output logic [31:0]      cpu_write_addr,
    output logic [31:0]      cpu_write_data,
    output logic             cpu_write_enable,
    output logic [31:0]      cpu_ctrl,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int TMR_MAX_A = (RST_CYCLES > ENTER_CYCLES) ? RST_CYCLES : ENTER_CYCLES;
    localparam int TMR_MAX   = (TMR_MAX_A > UPD_CYCLES) ? TMR_MAX_A : UPD_CYCLES;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);

    state_t           state;
    state_t           state_next;
    logic [TMR_W-1:0] tmr;
    logic             tmr_done;
    logic             start_ok;
    logic             load_init;
    logic             last_xfer;
    logic             remaining_zero;

    // Timer value loaded on entry so the state lasts exactly its cycle count.
    function automatic logic [TMR_W-1:0] tmr_reload(input state_t s);
        logic [TMR_W-1:0] v;
        v = '0;
        case (s)
            RESET:   v = TMR_W'(RST_CYCLES - 1);
            ENTER:   v = TMR_W'(ENTER_CYCLES - 1);
            UPDATE:  v = TMR_W'(UPD_CYCLES - 1);
            default: v = '0;
        endcase
        return v;
    endfunction

    assign tmr_done = (tmr == '0);
    assign busy     = (state != IDLE);

`ifdef RESTORE_TIMEOUT_EN
    assign start_ok = (state == IDLE) || (state == ERR);
`else
    assign start_ok = (state == IDLE);
`endif

    // Abort beats a coincident start
    assign load_init = start && !abort && start_ok;

    restore_load_stage #(
        .CNT_W (CNT_W)
    ) u_load (
        .clk              (clk),
        .nreset           (nreset),
        .load_active      (state == LOAD),
        .abort            (abort),
        .load_init        (load_init),
        .n_words          (n_words),
        .dma_out          (dma_out),
        .dma_r_enable     (dma_r_enable),
        .dma_re           (dma_re),
        .last_xfer        (last_xfer),
        .remaining_zero   (remaining_zero),
        .cpu_write_addr   (cpu_write_addr),
        .cpu_write_data   (cpu_write_data),
        .cpu_write_enable (cpu_write_enable)
    );

`ifdef RESTORE_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               stall_hit;

    // Counts only cycles where a pop is wanted but the FIFO is empty.
    assign stall_hit = (state == LOAD) && dma_re && !dma_r_enable &&
                       (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            stall_cnt <= '0;
            error     <= 1'b0;
        end else begin
            if (state != LOAD || (dma_re && dma_r_enable)) begin
                stall_cnt <= '0;
            end else if (dma_re && !dma_r_enable) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end

            if (abort || load_init) begin
                error <= 1'b0;
            end else if (stall_hit) begin
                error <= 1'b1;
            end
        end
    end
`else
    assign error = 1'b0;
`endif

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = RESET;
                RESET:   if (tmr_done) state_next = ENTER;
                ENTER:   if (tmr_done) state_next = remaining_zero ? UPDATE : LOAD;
                LOAD: begin
                    if (last_xfer) begin
                        state_next = FLUSH;
                    end
`ifdef RESTORE_TIMEOUT_EN
                    else if (stall_hit) begin
                        state_next = ERR;
                    end
`endif
                end
                FLUSH:   state_next = UPDATE;
                UPDATE:  if (tmr_done) state_next = SETTLE;
                SETTLE:  state_next = RUN;
                RUN:     state_next = IDLE;
`ifdef RESTORE_TIMEOUT_EN
                ERR:     if (start) state_next = RESET;
`endif
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            tmr      <= '0;
            cpu_ctrl <= CTRL_HOLD;
            done     <= 1'b0;
        end else begin
            state <= state_next;

            if (state_next != state) begin
                tmr <= tmr_reload(state_next);
            end else if (!tmr_done) begin
                tmr <= tmr - TMR_W'(1);
            end

            // cpu_ctrl is registered from the next state so it lines up with the state itself.
            // Abort re-asserts CPU reset; a lone abort in IDLE leaves the word untouched.
            if (abort && (state != IDLE || start)) begin
                cpu_ctrl <= CTRL_HOLD;
            end else begin
                cpu_ctrl <= ctrl_word(state_next, cpu_ctrl);
            end

            done <= (state_next == RUN);
        end
    end

endmodule

// File: tb/tb_restore_seq.sv
// Testbench for restore_seq: queue-based FIFO model, run-length cpu_ctrl model, write scoreboard.
// Latency: n/a. Backpressure: FIFO valid driven from a per-cycle pattern (fixed or $urandom).
// Prints one FAIL line per mismatch and a single summary line at the end.
module tb_restore_seq;

    localparam int CNT_W = 16;
    localparam int UPD   = 2000;
    localparam int PRE   = 20;     // RST_CYCLES + ENTER_CYCLES

    logic             clk = 1'b0;
    logic             nreset;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] n_words;
    logic [63:0]      dma_out;
    logic             dma_r_enable;
    logic             dma_re;
    logic [31:0]      cpu_write_addr;
    logic [31:0]      cpu_write_data;
    logic             cpu_write_enable;
    logic [31:0]      cpu_ctrl;
    logic             busy;
    logic             done;
    logic             error;

    restore_seq #(
        .RST_CYCLES     (10),
        .ENTER_CYCLES   (10),
        .UPD_CYCLES     (UPD),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk              (clk),
        .nreset           (nreset),
        .start            (start),
        .abort            (abort),
        .n_words          (n_words),
        .dma_out          (dma_out),
        .dma_r_enable     (dma_r_enable),
        .dma_re           (dma_re),
        .cpu_write_addr   (cpu_write_addr),
        .cpu_write_data   (cpu_write_data),
        .cpu_write_enable (cpu_write_enable),
        .cpu_ctrl         (cpu_ctrl),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] q[$];        // FIFO contents, head at index 0
    logic [63:0] exp_wr[$];   // writes still expected, in order
    int          cv[$];       // observed cpu_ctrl run values
    int          cn[$];       // observed cpu_ctrl run lengths
    int          re_cnt;
    int          wr_cnt;
    int          done_at;
    int          exp_n;
    int          cyc = 0;
    int          t0  = 0;
    bit          mon_on = 1'b0;
    bit          vpat[0:8191];  // FIFO-valid offer per cycle, indexed relative to start

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        int k;
        k = cyc - t0;
        if (k < 0 || k > 8191) k = 0;
        dma_r_enable = (q.size() > 0) && vpat[k];
        dma_out      = (q.size() > 0) ? q[0] : 64'h0;
    endtask

    task automatic set_vpat(input int mode);
        for (int k = 0; k < 8192; k++) begin
            case (mode)
                0:       vpat[k] = 1'b1;
                1:       vpat[k] = (k < PRE + 1) ? 1'b1 : (((k - PRE - 1) % 4 == 0) || ((k - PRE - 1) % 4 == 3));
                default: vpat[k] = ($urandom_range(0, 1) == 1);
            endcase
        end
    endtask

    // One clock: observe outputs mid-cycle, apply the FIFO pop at the edge, re-drive inputs.
    task automatic tick();
        bit          pop;
        logic [63:0] w;
        @(negedge clk);
        if (mon_on && (cyc - t0) >= 1) begin
            if (cv.size() == 0 || cv[cv.size()-1] != int'(cpu_ctrl)) begin
                cv.push_back(int'(cpu_ctrl));
                cn.push_back(1);
            end else begin
                cn[cn.size()-1] = cn[cn.size()-1] + 1;
            end
            if (dma_re) re_cnt++;
            if (cpu_write_enable) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    check("write_overrun", wr_cnt, exp_n);
                end else begin
                    w = exp_wr.pop_front();
                    check("write_addr_data", {cpu_write_addr, cpu_write_data}, w);
                end
            end
            if (done && done_at < 0) done_at = cyc - t0;
        end
        pop = dma_re && dma_r_enable;
        @(posedge clk);
        cyc++;
        #1;
        if (pop && q.size() > 0) w = q.pop_front();
        start = 1'b0;
        abort = 1'b0;
        drive();
    endtask

    task automatic arm(input int n);
        exp_wr.delete();
        for (int i = 0; i < n && i < q.size(); i++) exp_wr.push_back(q[i]);
        exp_n   = n;
        cv.delete();
        cn.delete();
        re_cnt  = 0;
        wr_cnt  = 0;
        done_at = -1;
        mon_on  = 1'b1;
        t0      = cyc;
        n_words = CNT_W'(n);
        start   = 1'b1;
    endtask

    task automatic run_restore(input int n, input string tag);
        int ev[$];
        int en[$];
        int l_cyc;
        int cnt;
        int k;
        int guard;
        int exp_lat;
        l_cyc = 0; cnt = 0; k = PRE + 1; guard = 0;
        // Load phase length: cycles until the n-th offered valid word
        while (cnt < n && k < 8192) begin
            if (vpat[k]) cnt++;
            l_cyc++;
            k++;
        end
        ev.push_back(1);    en.push_back(10);
        ev.push_back(3);    en.push_back(10);
        if (n > 0) begin
            ev.push_back(7); en.push_back(l_cyc + 1);
        end
        ev.push_back('h43); en.push_back(UPD);
        ev.push_back(3);    en.push_back(1);
        ev.push_back(0);    en.push_back(1);
        exp_lat = (n > 0) ? (PRE + l_cyc + 1 + UPD + 2) : (PRE + UPD + 2);

        arm(n);
        tick();
        while (done_at < 0 && guard < 6000) begin
            tick();
            guard++;
        end
        mon_on = 1'b0;
        check({tag, "_done_latency"}, done_at, exp_lat);
        check({tag, "_write_count"}, wr_cnt, n);
        check({tag, "_pop_cycles"}, re_cnt, l_cyc);
        check({tag, "_ctrl_runs"}, cv.size(), ev.size());
        for (int i = 0; i < ev.size() && i < cv.size(); i++)
            check({tag, "_ctrl_seq"}, {cv[i], cn[i]}, {ev[i], en[i]});
        tick();
        check({tag, "_idle_after"}, {busy, done, error, cpu_ctrl}, 64'h0);
    endtask

    initial begin
        int n;
        int extra;
        int guard;
        nreset = 1'b1; start = 1'b0; abort = 1'b0; n_words = '0;
        dma_out = '0; dma_r_enable = 1'b0;
        set_vpat(0);

        // Reset values
        #2 nreset = 1'b0;
        #1;
        check("rst_ctrl", cpu_ctrl, 32'h1);
        check("rst_flags", {busy, done, error, dma_re, cpu_write_enable}, 0);
        check("rst_wr", {cpu_write_addr, cpu_write_data}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
        tick();

        // Nominal 64-word restore
        for (int i = 0; i < 64; i++) q.push_back({32'h8000_0000 + i, 32'hDEAD_BEAF + i});
        drive();
        run_restore(64, "nominal");

        // Stalled FIFO: 8 of 12 words, valid toggling 1-0-0-1
        q.delete();
        for (int i = 0; i < 12; i++) q.push_back({32'h2000_0000 + 4 * i, 32'hDEAD_BEAF + i});
        set_vpat(1);
        drive();
        run_restore(8, "stall");
        check("stall_fifo_left", q.size(), 4);

        // Zero words: load skipped, FIFO untouched
        set_vpat(0);
        drive();
        run_restore(0, "zero");
        check("zero_fifo_left", q.size(), 4);

        // Abort after 5 of 16 words, then resume with the remaining 11
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back({$urandom, $urandom});
        drive();
        arm(16);
        tick();
        guard = 0;
        while (q.size() > 11 && guard < 200) begin
            tick();
            guard++;
        end
        abort = 1'b1;
        tick();
        check("abort_ctrl", cpu_ctrl, 32'h1);
        check("abort_flags", {busy, dma_re, cpu_write_enable, done}, 0);
        repeat (5) tick();
        mon_on = 1'b0;
        check("abort_fifo_left", q.size(), 11);
        check("abort_writes", wr_cnt, 5);
        check("abort_no_done", done_at, -1);
        run_restore(11, "resume");

        // Randomized restores with random FIFO valid gaps
        for (int r = 0; r < 2; r++) begin
            q.delete();
            n     = $urandom_range(1, 24);
            extra = $urandom_range(0, 3);
            for (int i = 0; i < n + extra; i++) q.push_back({$urandom, $urandom});
            set_vpat(2);
            drive();
            run_restore(n, "random");
            check("random_fifo_left", q.size(), extra);
        end

        // Start during UPDATE ignored, then async reset mid-UPDATE
        q.delete();
        for (int i = 0; i < 2; i++) q.push_back({32'h8000_0000 + i, 32'hDEAD_BEAF + i});
        set_vpat(0);
        drive();
        arm(2);
        tick();
        guard = 0;
        while ((cyc - t0) < 500 && guard < 1000) begin
            tick();
            guard++;
        end
        start   = 1'b1;
        n_words = CNT_W'(5);
        tick();
        repeat (10) tick();
        check("upd_start_ignored", {busy, cpu_ctrl}, {1'b1, 32'h43});
        mon_on = 1'b0;
        #2 nreset = 1'b0;
        #1;
        check("nrst_ctrl", cpu_ctrl, 32'h1);
        check("nrst_flags", {busy, done, error, dma_re, cpu_write_enable}, 0);
        check("nrst_wr", {cpu_write_addr, cpu_write_data}, 0);
        @(negedge clk);
        nreset = 1'b1;
        tick();

`ifdef RESTORE_TIMEOUT_EN
        // Empty FIFO: ERR after 16 stall cycles, abort clears error
        q.delete();
        drive();
        arm(4);
        tick();
        guard = 0;
        while ((cyc - t0) < PRE + 1 + 16 && guard < 200) begin
            tick();
            guard++;
        end
        check("timeout_err", {error, busy, dma_re, cpu_ctrl}, {3'b110, 32'h1});
        abort = 1'b1;
        tick();
        mon_on = 1'b0;
        check("timeout_abort", {error, busy}, 0);
`else
        check("error_tied_low", error, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/restore_seq.md
Name: restore_seq

Overview:
- Sequencer that performs a CPU state restore: holds `cpu_top` in reset, enters restore mode, then drains N {addr,data} pairs from the `dma_trans` read side into the CPU write port.
- After the load it issues a register update and then releases the CPU to run.
- Replaces hand-driven `cpu_ctrl_in` sequencing. Sits between `dma_trans` (`dma_out` / `dma_re` / `dma_r_enable`) and `cpu_top` (`cpu_write_*` / `cpu_ctrl_in`).

Parameters:
- RST_CYCLES, 10, cycles CPU is held in reset before entering restore mode.
- ENTER_CYCLES, 10, cycles in restore mode before the load starts.
- UPD_CYCLES, 2000, cycles the register-update command is held.
- CNT_W, 16, width of the word count.
- TIMEOUT_CYCLES, 4096, load stall limit (used only with the optional feature).

Ports:
- clk  in  1  single clock.
- nreset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a restore when idle.
- abort  in  1  one-cycle pulse; cancels a restore from any state.
- n_words  in  CNT_W  number of {addr,data} pairs to load; sampled on start.
- dma_out  in  64  FIFO head word; [63:32] address, [31:0] data.
- dma_r_enable  in  1  FIFO head valid (first-word-fall-through).
- dma_re  out  1  FIFO pop request.
- cpu_write_addr  out  32  registered write address to the CPU.
- cpu_write_data  out  32  registered write data to the CPU.
- cpu_write_enable  out  1  registered write strobe to the CPU.
- cpu_ctrl  out  32  CPU control word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- error  out  1  sticky load-timeout flag.

Behaviour:
- Reset values: `cpu_ctrl` = 0x00000001 (CPU held in reset). All other outputs 0. FSM in IDLE.
- Control bits: bit0 CPU_RST, bit1 RESTORE_MODE, bit2 REG_WRITE, bit6 REG_UPDATE. All other bits 0.
- `cpu_ctrl` is a register; its value per state is listed below.
- **IDLE**:
  - `cpu_ctrl` holds its previous value.
  - `start` (with `abort` low): latch `n_words` into `remaining`, go to RESET.
  - `start` while busy is ignored.
- **RESET**: `cpu_ctrl` = 0x1 for RST_CYCLES cycles, then go to ENTER.
- **ENTER**: `cpu_ctrl` = 0x3 for ENTER_CYCLES cycles. Then go to LOAD, or go directly to UPDATE if `remaining` == 0.
- **LOAD**:
  - `cpu_ctrl` = 0x7.
  - `dma_re` = (state==LOAD) && (`remaining` != 0). This is combinational, so no over-read occurs.
  - Transfer occurs in any cycle with `dma_re` && `dma_r_enable`:
    - `remaining` decrements.
    - Next cycle: `cpu_write_addr` = `dma_out[63:32]`, `cpu_write_data` = `dma_out[31:0]`, `cpu_write_enable` = 1.
  - `cpu_write_enable` is 0 in every cycle without a transfer. Address/data hold their last values.
  - When the last transfer occurs, go to FLUSH.
- **FLUSH**: one cycle. `cpu_ctrl` = 0x7 so the final registered write lands. Then go to UPDATE.
- **UPDATE**: `cpu_ctrl` = 0x43 for UPD_CYCLES cycles, then go to SETTLE.
- **SETTLE**: `cpu_ctrl` = 0x3 for one cycle, then go to RUN.
- **RUN**: `cpu_ctrl` = 0x0, `done` = 1 for this cycle, then go to IDLE. `cpu_ctrl` stays 0 until the next start.
- **abort** (highest priority, any non-IDLE state):
  - Next cycle: IDLE, `cpu_ctrl` = 0x1, `dma_re` = 0, `cpu_write_enable` = 0, no `done`.
  - `abort` coinciding with `start` in IDLE: `abort` wins, and `cpu_ctrl` = 0x1.
- Cycle counters are sized to max(RST_CYCLES, ENTER_CYCLES, UPD_CYCLES) and reloaded on every state entry.
- `remaining` never wraps: it decrements only when nonzero.
- `dma_r_enable` high outside LOAD has no effect.
- Asynchronous `nreset` mid-operation returns the block to reset values immediately. Any in-flight FIFO word is not consumed.
- `error` is cleared on `start` or `abort`.
- Latency: a restore with n_words=N and no FIFO stalls takes RST_CYCLES + ENTER_CYCLES + N + 1 + UPD_CYCLES + 2 cycles from `start` to the `done` pulse.

Optional Feature:
- Macro: RESTORE_TIMEOUT_EN.
- With the macro defined:
  - A stall counter runs in LOAD. It resets on each transfer and counts cycles with `dma_re` high and `dma_r_enable` low.
  - On reaching TIMEOUT_CYCLES the FSM goes to ERR: `cpu_ctrl` = 0x1, `error` = 1, `busy` = 1, `dma_re` = 0.
  - ERR is left only via `abort` (to IDLE, `error` cleared) or `start` (to RESET with `n_words` reloaded).
- Without the macro: LOAD waits indefinitely, `error` is tied to 0, and the ERR state and stall counter do not exist.

Decomposition:
- Package `restore_pkg`:
  - FSM state enum (IDLE, RESET, ENTER, LOAD, FLUSH, UPDATE, SETTLE, RUN, ERR).
  - Control-bit positions.
  - Constants CTRL_HOLD=0x1, CTRL_RESTORE=0x3, CTRL_LOAD=0x7, CTRL_UPDATE=0x43, CTRL_RUN=0x0.
- Sub-module `restore_load_stage`: the LOAD pop/capture register stage (`dma_re` generation, `remaining` counter, registered `cpu_write_*`). FSM and timers stay in `restore_seq`.

Test Plan:
- Nominal: preload 64 pairs (addr 0x80000000+i / 0x20000000+4i, data 0xDEADBEAF+i), n_words=64, start -> `cpu_ctrl` sequence 1,3,7,0x43,3,0. Exactly 64 writes with matching addr/data in order, and `done` after 10+10+64+1+2000+2 cycles.
- Stalled FIFO: 8 words with `dma_r_enable` toggled 1-0-0-1 -> writes only on valid cycles, `dma_re` drops the cycle after the 8th transfer, and no 9th pop.
- n_words=0 -> LOAD skipped, `dma_re` never asserted, `done` after 10+10+2000+2 cycles.
- Abort in LOAD after 5 of 16 words -> next cycle IDLE, `cpu_ctrl`=0x1, `dma_re`=0, FIFO retains 11 words, no `done`. A following start with n_words=11 completes.
- `start` during UPDATE is ignored; async `nreset` pulse mid-UPDATE -> `cpu_ctrl`=0x1 and all other outputs 0 immediately.
- RESTORE_TIMEOUT_EN, TIMEOUT_CYCLES=16, FIFO empty -> ERR after 16 stall cycles, `error`=1, `cpu_ctrl`=0x1. Abort clears `error`.
